// File: rtl/booth_mult_if.sv
// Bundle for the Booth multiplier: request/result handshake plus the
// shared-adder borrow port.
interface booth_mult_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;
    logic             busy;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             overflow;
    logic             result_rdy;

    modport master (
        output start, operand_a, operand_b, adder_sum,
        input  adder_a, adder_b, adder_cin,
        input  busy, result_hi, result_lo,
        input  overflow, result_rdy
    );

    modport slave (
        input  start, operand_a, operand_b, adder_sum,
        output adder_a, adder_b, adder_cin,
        output busy, result_hi, result_lo,
        output overflow, result_rdy
    );
endinterface

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiplier controller driving a borrowed WIDTH-bit adder,
// one add/sub/pass plus arithmetic shift per RUN cycle.
module booth_mult_ctrl #(
    parameter int WIDTH = 32
) (
    input logic        clock,
    input logic        reset,
    booth_mult_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             x;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_ovf;

    logic             run;
    logic             last;
    logic             sel_add;
    logic             sel_sub;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             ovf_i;
    logic             s;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]   top_bits;

    always_comb begin
        run     = (state == RUN);
        last    = (cnt == CNT_LAST);
        sel_add = run & ~lo[0] & x;
        sel_sub = run & lo[0] & ~x;
        add_a   = run ? hi : '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (1'b1)
            sel_add: add_b = m;
            sel_sub: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: begin
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    // Recover the 33rd sum bit so M = most-negative shifts in the right sign.
    always_comb begin
        ovf_i = (add_a[WIDTH-1] == add_b[WIDTH-1])
              & (bus.adder_sum[WIDTH-1] != add_a[WIDTH-1]);
        s        = bus.adder_sum[WIDTH-1] ^ ovf_i;
        prod_nxt = {s, bus.adder_sum, lo[WIDTH-1:1]};
        top_bits = prod_nxt[2*WIDTH-1:WIDTH-1];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            x       <= 1'b0;
            cnt     <= '0;
            res_hi  <= '0;
            res_lo  <= '0;
            res_ovf <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            m   <= bus.operand_a;
            hi  <= '0;
            lo  <= bus.operand_b;
            x   <= 1'b0;
            cnt <= '0;
        end else if (run) begin
            hi  <= prod_nxt[2*WIDTH-1:WIDTH];
            lo  <= prod_nxt[WIDTH-1:0];
            x   <= lo[0];
            cnt <= cnt + 1'b1;
            if (last) begin
                res_hi  <= prod_nxt[2*WIDTH-1:WIDTH];
                res_lo  <= prod_nxt[WIDTH-1:0];
                res_ovf <= ~((&top_bits) | ~(|top_bits));
            end
        end
    end

    assign bus.adder_a    = add_a;
    assign bus.adder_b    = add_b;
    assign bus.adder_cin  = add_cin;
    assign bus.busy       = (state != IDLE);
    assign bus.result_rdy = (state == DONE);
    assign bus.result_hi  = res_hi;
    assign bus.result_lo  = res_lo;
    assign bus.overflow   = res_ovf;
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Bench for booth_mult_ctrl: directed corner products, disturbance
// scenarios and randomized pairs against a 64-bit signed model.
module tb_booth_mult_ctrl;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    booth_mult_if #(.WIDTH(W)) bus ();

    assign bus.adder_sum = bus.adder_a + bus.adder_b + W'(bus.adder_cin);

    booth_mult_ctrl #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_hi;
    logic [W-1:0] held_lo;
    logic         held_ovf;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet_adder(input string tag);
        check({tag, "_a"}, 64'(bus.adder_a), 64'd0);
        check({tag, "_b"}, 64'(bus.adder_b), 64'd0);
        check({tag, "_cin"}, 64'(bus.adder_cin), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_rdy"}, 64'(bus.result_rdy), 64'd0);
        check({tag, "_hi"}, 64'(bus.result_hi), 64'd0);
        check({tag, "_lo"}, 64'(bus.result_lo), 64'd0);
        check({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
        check_quiet_adder(tag);
    endtask

    function automatic logic [64:0] ref_mult(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
        return {(p != {{32{p[31]}}, p[31:0]}), p};
    endfunction

    function automatic logic [W-1:0] pick();
        unique case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after a rising edge with the DUT in IDLE.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_hi,
                            input logic [W-1:0] exp_lo,
                            input logic exp_ovf,
                            input int pulse_at, input int reset_at);
        int   edges;
        int   i;
        logic done;
        logic q_i;
        logic q_p;
        logic [W-1:0] eb;
        logic ecin;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        check_quiet_adder("idle_adder");
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        edges = 1;
        done  = 1'b0;
        while (!done && edges <= 40) begin
            if (bus.result_rdy) begin
                check("latency", 64'(edges), 64'd33);
                check("hi", 64'(bus.result_hi), 64'(exp_hi));
                check("lo", 64'(bus.result_lo), 64'(exp_lo));
                check("ovf", 64'(bus.overflow), 64'(exp_ovf));
                check("done_busy", 64'(bus.busy), 64'd1);
                check_quiet_adder("done_adder");
                held_hi  = exp_hi;
                held_lo  = exp_lo;
                held_ovf = exp_ovf;
                bus.start     = 1'b1;
                bus.operand_a = $urandom;
                bus.operand_b = $urandom;
                @(posedge clock);
                #1;
                bus.start = 1'b0;
                check("rdy_pulse", 64'(bus.result_rdy), 64'd0);
                check("done_start_ignored", 64'(bus.busy), 64'd0);
                check("after_hi", 64'(bus.result_hi), 64'(exp_hi));
                check("after_lo", 64'(bus.result_lo), 64'(exp_lo));
                done = 1'b1;
            end else begin
                i   = edges - 1;
                q_i = b[i];
                q_p = (i == 0) ? 1'b0 : b[i-1];
                eb  = (q_i & ~q_p) ? ~a : ((~q_i & q_p) ? a : '0);
                ecin = q_i & ~q_p;
                check("run_busy", 64'(bus.busy), 64'd1);
                check("run_adder_b", 64'(bus.adder_b), 64'(eb));
                check("run_adder_cin", 64'(bus.adder_cin), 64'(ecin));
                check("run_hold_hi", 64'(bus.result_hi), 64'(held_hi));
                check("run_hold_lo", 64'(bus.result_lo), 64'(held_lo));
                check("run_hold_ovf", 64'(bus.overflow), 64'(held_ovf));
                if (i == pulse_at) begin
                    bus.start     = 1'b1;
                    bus.operand_a = $urandom;
                    bus.operand_b = $urandom;
                end else begin
                    bus.start = 1'b0;
                end
                if (i == reset_at) begin
                    reset = 1'b1;
                    @(posedge clock);
                    #1;
                    reset = 1'b0;
                    check_all_zero("midrun_reset");
                    held_hi  = '0;
                    held_lo  = '0;
                    held_ovf = 1'b0;
                    repeat (15) begin
                        @(posedge clock);
                        #1;
                        check("no_rdy_after_reset", 64'(bus.result_rdy), 64'd0);
                    end
                    done = 1'b1;
                end else begin
                    @(posedge clock);
                    #1;
                    edges++;
                end
            end
        end
        check("completed", 64'(done), 64'd1);
    endtask

    task automatic run_model(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int pulse_at);
        logic [64:0] r;
        r = ref_mult(a, b);
        run_mult(a, b, r[63:32], r[31:0], r[64], pulse_at, -1);
    endtask

    initial begin
        held_hi       = '0;
        held_lo       = '0;
        held_ovf      = 1'b0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_all_zero("post_reset");

        run_mult(32'd3, 32'd5, 32'h0, 32'd15, 1'b0, -1, -1);
        run_mult(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6,
                 1'b0, -1, -1);
        run_mult(32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, -1, -1);
        run_mult(32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
                 1'b1, -1, -1);
        run_mult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
                 1'b1, -1, -1);
        run_mult(32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b1, -1, -1);
        run_mult(32'h7FFF_FFFF, 32'h1, 32'h0, 32'h7FFF_FFFF, 1'b0, -1, -1);

        run_model(32'h0012_3457, 32'hFFFE_9876, 10);
        run_mult(32'h1234_5678, 32'h9ABC_DEF1, 32'h0, 32'h0, 1'b0, -1, 20);
        run_mult(32'd3, 32'd5, 32'h0, 32'd15, 1'b0, -1, -1);

        for (int n = 0; n < 1000; n++) begin
            run_model(pick(), pick(), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
